// File: rtl/stage_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stage_2 (with helper dual_port_ram)                             |
// | Purpose  : Second radix-2 DIT stage of the 1024-point FFT. Applies the     |
// |            trivial twiddles (1 or -j), performs a scaled butterfly, stores |
// |            results into a ping-pong RAM and reads pairs at distance 4 for  |
// |            the third stage, one frame behind the writes.                   |
// | Ports    : i_clk, i_reset (async, active-low)                              |
// |            i_valid_in            - one pulse per pair, data next cycle     |
// |            i_data_{a,b}_{real,imag} [31:0] - input pair (signed)           |
// |            o_valid_out           - output pair strobe (registered)         |
// |            o_data_{a,b}_{real,imag} [31:0] - output pair, distance 4       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

// Two-port RAM, both ports read/write, synchronous read with one-cycle latency.
module dual_port_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] wdata_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[addr_a_i] <= wdata_a_i;
    if (we_b_i) mem_q[addr_b_i] <= wdata_b_i;
    rdata_a_q <= mem_q[addr_a_i];
    rdata_b_q <= mem_q[addr_b_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

module stage_2 (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid_in,
  input  logic [31:0] i_data_a_real,
  input  logic [31:0] i_data_a_imag,
  input  logic [31:0] i_data_b_real,
  input  logic [31:0] i_data_b_imag,
  output logic        o_valid_out,
  output logic [31:0] o_data_a_real,
  output logic [31:0] o_data_a_imag,
  output logic [31:0] o_data_b_real,
  output logic [31:0] o_data_b_imag
);

  localparam logic [8:0] LAST_PAIR = 9'd511;

  // Registered state
  logic        in_valid_q;
  logic        bf_valid_q;
  logic [31:0] bf_a_re_q, bf_a_im_q, bf_b_re_q, bf_b_im_q;
  logic [8:0]  in_cnt_q, in_cnt_d;
  logic [8:0]  rd_cnt_q, rd_cnt_d;
  logic        bank_sel_q, bank_sel_d;
  logic        read_en_q, read_en_d;
  logic        rd_bank_q, rd_bank_d;
  logic        valid_out_q, valid_out_d;

  // ---------------------------------------------------------------------------
  // Butterfly. in_cnt only advances when a result is written, so the pair now
  // in the butterfly is one ahead of in_cnt if a write is pending this cycle.
  // ---------------------------------------------------------------------------
  logic               odd_pair;
  logic signed [32:0] a_re_x, a_im_x, b_re_x, b_im_x;
  logic signed [32:0] wb_re, wb_im;
  logic signed [32:0] sum_re, sum_im, dif_re, dif_im;

  assign odd_pair = in_cnt_q[0] ^ bf_valid_q;

  assign a_re_x = {i_data_a_real[31], i_data_a_real};
  assign a_im_x = {i_data_a_imag[31], i_data_a_imag};
  assign b_re_x = {i_data_b_real[31], i_data_b_real};
  assign b_im_x = {i_data_b_imag[31], i_data_b_imag};

  // Odd pairs use W = -j: (Br + jBi)(-j) = Bi - jBr. Negating at 33 bits keeps
  // -(-2^31) exact.
  assign wb_re = odd_pair ? b_im_x : b_re_x;
  assign wb_im = odd_pair ? -b_re_x : b_im_x;

  // 33-bit sums cannot overflow; dropping bit 0 is the >>>1 scaling.
  assign sum_re = a_re_x + wb_re;
  assign sum_im = a_im_x + wb_im;
  assign dif_re = a_re_x - wb_re;
  assign dif_im = a_im_x - wb_im;

  logic unused_lsbs;
  assign unused_lsbs = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      in_valid_q <= 1'b0;
      bf_valid_q <= 1'b0;
      bf_a_re_q  <= '0;
      bf_a_im_q  <= '0;
      bf_b_re_q  <= '0;
      bf_b_im_q  <= '0;
    end else begin
      in_valid_q <= i_valid_in;
      bf_valid_q <= in_valid_q;
      if (in_valid_q) begin
        bf_a_re_q <= sum_re[32:1];
        bf_a_im_q <= sum_im[32:1];
        bf_b_re_q <= dif_re[32:1];
        bf_b_im_q <= dif_im[32:1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write / read control. Reads are paced by writes and go to the other bank.
  // ---------------------------------------------------------------------------
  logic       wr_en;
  logic       rd_en;
  logic [9:0] wr_addr_a, wr_addr_b;
  logic [9:0] rd_addr_a, rd_addr_b;

  assign wr_en     = bf_valid_q;
  assign rd_en     = bf_valid_q & read_en_q;
  assign wr_addr_a = {in_cnt_q[8:1], 1'b0, in_cnt_q[0]};
  assign wr_addr_b = {in_cnt_q[8:1], 1'b1, in_cnt_q[0]};
  assign rd_addr_a = {rd_cnt_q[8:2], 1'b0, rd_cnt_q[1:0]};
  assign rd_addr_b = {rd_cnt_q[8:2], 1'b1, rd_cnt_q[1:0]};

  always_comb begin
    in_cnt_d    = in_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    bank_sel_d  = bank_sel_q;
    read_en_d   = read_en_q;
    rd_bank_d   = rd_bank_q;
    valid_out_d = rd_en;
    if (wr_en) begin
      in_cnt_d = in_cnt_q + 9'd1;
      if (in_cnt_q == LAST_PAIR) begin
        bank_sel_d = ~bank_sel_q;
        read_en_d  = 1'b1;
      end
    end
    if (rd_en) begin
      rd_cnt_d  = rd_cnt_q + 9'd1;
      rd_bank_d = ~bank_sel_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      in_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      bank_sel_q  <= 1'b0;
      read_en_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      bank_sel_q  <= bank_sel_d;
      read_en_q   <= read_en_d;
      rd_bank_q   <= rd_bank_d;
      valid_out_q <= valid_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong RAM banks (real and imag per bank).
  // ---------------------------------------------------------------------------
  logic [1:0][31:0] ram_a_re, ram_a_im, ram_b_re, ram_b_im;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic       is_wr;
    logic       we;
    logic [9:0] addr_a, addr_b;

    assign is_wr  = (bank_sel_q == 1'(b));
    assign we     = wr_en & is_wr;
    assign addr_a = is_wr ? wr_addr_a : rd_addr_a;
    assign addr_b = is_wr ? wr_addr_b : rd_addr_b;

    dual_port_ram #(.ADDR_W(10), .DATA_W(32)) u_ram_re (
      .clk_i     (i_clk),
      .we_a_i    (we),
      .addr_a_i  (addr_a),
      .wdata_a_i (bf_a_re_q),
      .rdata_a_o (ram_a_re[b]),
      .we_b_i    (we),
      .addr_b_i  (addr_b),
      .wdata_b_i (bf_b_re_q),
      .rdata_b_o (ram_b_re[b])
    );

    dual_port_ram #(.ADDR_W(10), .DATA_W(32)) u_ram_im (
      .clk_i     (i_clk),
      .we_a_i    (we),
      .addr_a_i  (addr_a),
      .wdata_a_i (bf_a_im_q),
      .rdata_a_o (ram_a_im[b]),
      .we_b_i    (we),
      .addr_b_i  (addr_b),
      .wdata_b_i (bf_b_im_q),
      .rdata_b_o (ram_b_im[b])
    );
  end

  // Output data is forced to zero when not valid so that reset (which cannot
  // clear the RAM read registers) leaves all outputs at zero.
  always_comb begin
    o_valid_out   = valid_out_q;
    o_data_a_real = '0;
    o_data_a_imag = '0;
    o_data_b_real = '0;
    o_data_b_imag = '0;
    if (valid_out_q) begin
      o_data_a_real = ram_a_re[rd_bank_q];
      o_data_a_imag = ram_a_im[rd_bank_q];
      o_data_b_real = ram_b_re[rd_bank_q];
      o_data_b_imag = ram_b_im[rd_bank_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stage_2                                                      |
// | Purpose  : Directed, table-driven bench for stage_2: twiddle/butterfly     |
// |            vectors, output reorder, latency, gaps and mid-frame reset.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_stage_2;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid_in = 1'b0;
  logic [31:0] i_data_a_real = '0, i_data_a_imag = '0;
  logic [31:0] i_data_b_real = '0, i_data_b_imag = '0;
  logic        o_valid_out;
  logic [31:0] o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag;

  always #5 i_clk = ~i_clk;

  stage_2 dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid_in    (i_valid_in),
    .i_data_a_real (i_data_a_real),
    .i_data_a_imag (i_data_a_imag),
    .i_data_b_real (i_data_b_real),
    .i_data_b_imag (i_data_b_imag),
    .o_valid_out   (o_valid_out),
    .o_data_a_real (o_data_a_real),
    .o_data_a_imag (o_data_a_imag),
    .o_data_b_real (o_data_b_real),
    .o_data_b_imag (o_data_b_imag)
  );

  // Input pair j of frame 0 and its hand-computed butterfly result (A', B').
  typedef struct {
    int          j;
    logic [31:0] ar, ai, br, bi;
    logic [31:0] ear, eai, ebr, ebi;
  } vec_t;

  vec_t vecs[10];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit cap_on = 1'b0;
  logic [127:0] cap_data[$];
  int           cap_cyc[$];
  int           vin_cyc[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
    if (cap_on && o_valid_out === 1'b1) begin
      cap_data.push_back({o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag});
      cap_cyc.push_back(cyc);
    end
  endtask

  function automatic int find_vec(input int j);
    for (int i = 0; i < 10; i++) if (vecs[i].j == j) return i;
    return -1;
  endfunction

  // Frame 0: table pairs, otherwise A.real = 2j, B.real = 2j+1. Later frames: zeros.
  function automatic void get_in(input int f, input int j,
                                 output logic [31:0] ar, ai, br, bi);
    int v;
    v = find_vec(j);
    if (f != 0) begin
      ar = '0; ai = '0; br = '0; bi = '0;
    end else if (v >= 0) begin
      ar = vecs[v].ar; ai = vecs[v].ai; br = vecs[v].br; bi = vecs[v].bi;
    end else begin
      ar = 32'(2 * j); ai = '0; br = 32'(2 * j + 1); bi = '0;
    end
  endfunction

  // Expected butterfly result of frame-0 pair j.
  function automatic void exp_out(input int j, output logic [31:0] ear, eai, ebr, ebi);
    int v;
    v = find_vec(j);
    if (v >= 0) begin
      ear = vecs[v].ear; eai = vecs[v].eai; ebr = vecs[v].ebr; ebi = vecs[v].ebi;
    end else if ((j % 2) == 0) begin
      // A' = (4j+1)>>>1 = 2j, B' = (-1)>>>1 = -1
      ear = 32'(2 * j); eai = '0; ebr = 32'hFFFF_FFFF; ebi = '0;
    end else begin
      // W.B = (0, -(2j+1)): A' = (j, -(j+1)), B' = (j, j)
      ear = 32'(j); eai = 32'(-(j + 1)); ebr = 32'(j); ebi = 32'(j);
    end
  endfunction

  // Value held at stored frame index idx: pair {idx[9:2], idx[0]}, B' if idx[1].
  function automatic logic [63:0] stored_val(input int idx);
    logic [9:0]  ii;
    int          j;
    logic [31:0] ear, eai, ebr, ebi;
    ii = idx[9:0];
    j  = int'({ii[9:2], ii[0]});
    exp_out(j, ear, eai, ebr, ebi);
    return ii[1] ? {ebr, ebi} : {ear, eai};
  endfunction

  function automatic logic [127:0] exp_output(input int k);
    logic [8:0] kk;
    kk = k[8:0];
    return {stored_val(int'({kk[8:2], 1'b0, kk[1:0]})),
            stored_val(int'({kk[8:2], 1'b1, kk[1:0]}))};
  endfunction

  task automatic drive_data(input logic [31:0] ar, ai, br, bi);
    i_data_a_real = ar; i_data_a_imag = ai; i_data_b_real = br; i_data_b_imag = bi;
  endtask

  // Streams np pairs (frame = p/512) starting at cycle 0, optionally with idle gaps.
  task automatic run_stream(input int np, input bit gaps, input bit drain);
    logic [31:0] pr, pi, qr, qi;
    logic [31:0] nr, ni, mr, mi;
    bit have;
    int g;
    have = 1'b0;
    pr = '0; pi = '0; qr = '0; qi = '0;
    cap_data.delete(); cap_cyc.delete(); vin_cyc.delete();
    cap_on = 1'b1;
    cyc = 0;
    for (int p = 0; p < np; p++) begin
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < g; k++) begin
        i_valid_in = 1'b0;
        if (have) drive_data(pr, pi, qr, qi);
        else drive_data($urandom, $urandom, $urandom, $urandom);
        have = 1'b0;
        tick();
      end
      i_valid_in = 1'b1;
      if (have) drive_data(pr, pi, qr, qi);
      else drive_data($urandom, $urandom, $urandom, $urandom);
      get_in(p / 512, p % 512, nr, ni, mr, mi);
      pr = nr; pi = ni; qr = mr; qi = mi;
      have = 1'b1;
      vin_cyc.push_back(cyc);
      tick();
    end
    i_valid_in = 1'b0;
    drive_data(pr, pi, qr, qi);
    tick();
    if (drain) begin
      for (int k = 0; k < 8; k++) begin
        drive_data($urandom, $urandom, $urandom, $urandom);
        tick();
      end
    end
  endtask

  // Compares the first n outputs of the flush frame against the frame-0 model.
  task automatic check_frame(input string name, input int n, input bit cadence);
    chk({name, " output count"}, 128'(cap_data.size()), 128'(n));
    for (int k = 0; k < n && k < cap_data.size(); k++) begin
      chk($sformatf("%s out[%0d]", name, k), cap_data[k], exp_output(k));
      if (cadence && (512 + k) < vin_cyc.size())
        chk($sformatf("%s out[%0d] cycle", name, k), 128'(cap_cyc[k]), 128'(vin_cyc[512 + k] + 3));
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_valid_in = 1'b0;
    repeat (3) tick();
    i_reset = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    vecs[0] = '{0,   32'h0000_1000, 32'h0, 32'h0000_0800, 32'h0,
                     32'h0000_0C00, 32'h0, 32'h0000_0400, 32'h0};
    vecs[1] = '{1,   32'h0000_1000, 32'h0, 32'h0000_0800, 32'h0,
                     32'h0000_0800, 32'hFFFF_FC00, 32'h0000_0800, 32'h0000_0400};
    vecs[2] = '{2,   32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h0,
                     32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{3,   32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0,
                     32'hC000_0000, 32'h4000_0000, 32'hC000_0000, 32'hC000_0000};
    vecs[4] = '{4,   32'h0000_0003, 32'hFFFF_FFFD, 32'h0, 32'h0,
                     32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[5] = '{5,   32'h0000_0010, 32'h0000_0020, 32'h0000_0006, 32'h0000_0004,
                     32'h0000_000A, 32'h0000_000D, 32'h0000_0006, 32'h0000_0013};
    vecs[6] = '{6,   32'h0000_0100, 32'h0000_0200, 32'h0000_0050, 32'h0000_0030,
                     32'h0000_00A8, 32'h0000_0118, 32'h0000_0058, 32'h0000_00E8};
    vecs[7] = '{7,   32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_0001,
                     32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[8] = '{510, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    vecs[9] = '{511, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000,
                     32'hC000_0000, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000};

    // Reset held with random inputs: every output must be zero.
    i_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i_valid_in = 1'($urandom_range(0, 1));
      drive_data($urandom, $urandom, $urandom, $urandom);
      tick();
      chk("reset outputs", {o_valid_out, o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag},
          128'h0);
    end
    i_reset = 1'b1;
    i_valid_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("idle after reset valid", 128'(o_valid_out), 128'h0);
    end

    // Gap-free run: frame 0 plus a zero flush frame.
    run_stream(1024, 1'b0, 1'b1);
    cap_on = 1'b0;
    chk("first valid cycle", 128'(cap_cyc.size() > 0 ? cap_cyc[0] : -1), 128'(515));
    if (cap_data.size() >= 4) begin
      chk("even twiddle idx0 real", 128'(cap_data[0][127:96]), 128'h0000_0C00);
      chk("even twiddle idx2 real", 128'(cap_data[2][127:96]), 128'h0000_0400);
      chk("even twiddle imag",      128'({cap_data[0][95:64], cap_data[2][95:64]}), 128'h0);
      chk("odd twiddle idx1",       128'(cap_data[1][127:64]), {64'h0, 32'h0000_0800, 32'hFFFF_FC00});
      chk("odd twiddle idx3",       128'(cap_data[3][127:64]), {64'h0, 32'h0000_0800, 32'h0000_0400});
      chk("max even A'",            128'(cap_data[0][63:32]), 128'h7FFF_FFFF);
      chk("max even B'",            128'(cap_data[2][63:32]), 128'h0);
      chk("min odd A'",             128'(cap_data[1][63:0]), {64'h0, 32'hC000_0000, 32'h4000_0000});
      chk("min odd B'",             128'(cap_data[3][63:0]), {64'h0, 32'hC000_0000, 32'hC000_0000});
    end else begin
      chk("hand checks output count", 128'(cap_data.size()), 128'(512));
    end
    check_frame("gapfree", 512, 1'b1);

    // Same data with random idle cycles between pairs.
    do_reset();
    run_stream(1024, 1'b1, 1'b1);
    cap_on = 1'b0;
    check_frame("gaps", 512, 1'b1);

    // Reset at pair 300 of frame 1 while outputs are flowing.
    do_reset();
    run_stream(812, 1'b0, 1'b0);
    chk("valid before midframe reset", 128'(o_valid_out), 128'h1);
    i_reset = 1'b0;
    #1;
    chk("valid drops on reset", 128'(o_valid_out), 128'h0);
    cap_on = 1'b0;
    check_frame("partial", 299, 1'b1);
    repeat (3) tick();
    i_reset = 1'b1;
    repeat (2) tick();
    run_stream(1024, 1'b0, 1'b1);
    cap_on = 1'b0;
    chk("post-reset first valid cycle", 128'(cap_cyc.size() > 0 ? cap_cyc[0] : -1), 128'(515));
    check_frame("after reset", 512, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_2.md
# stage_2

Second radix-2 decimation-in-time stage of the 1024-point fixed-point FFT. Consumes butterfly pairs at distance 2 from the first stage and applies the trivial stage-2 twiddles (W = 1 or −j), so no CORDIC rotation is needed. It performs a scaled butterfly and stores the results in a ping-pong RAM. Pairs at distance 4 are read out for the third stage.

## Interface

- No parameters. N = 1024 and 512 pairs per frame are fixed.
- i_clk  in  1  clock; all state is updated on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid_in  in  1  one pulse per incoming pair; the pair data arrives on the following cycle.
- i_data_a_real, i_data_a_imag  in  32  input A, signed two's complement, valid the cycle after i_valid_in.
- i_data_b_real, i_data_b_imag  in  32  input B, same format and timing as A.
- o_valid_out  out  1  registered; high on the same cycle as the output pair.
- o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag  out  32  output pair (A, B) at index distance 4.

## Operation

- Pair counter in_cnt (9 bit):
  - Increments once per accepted pair and wraps 511→0.
  - Its value selects the write addresses and the twiddle.
- Twiddle, from in_cnt[0] of the pair:
  - Even pair: W·B = (Br, Bi).
  - Odd pair: W·B = (Bi, −Br).
  - Negation is done at 33 bits, so −(−2^31) is exact.
- Butterfly:
  - A' = (A + W·B) >>> 1 and B' = (A − W·B) >>> 1, computed per component.
  - Sums are 33-bit; bits [32:1] are kept (arithmetic shift, truncation toward −∞). The result cannot overflow.
- Write addresses for pair j: A' to {j[8:1],0,j[0]}, B' to {j[8:1],1,j[0]}.
  - Both are written in the same cycle through the two ports of the team's dual_port_ram (1024×32, synchronous read, one-cycle latency).
  - There are four instances: real and imag for bank 0 and bank 1.
- Ping-pong banks:
  - bank_sel selects the write bank; the other bank is the read bank.
  - bank_sel toggles after the 512th write of a frame; read_enable is set at that point and stays set until reset.
- Read side, paced by writes:
  - Every RAM write cycle with read_enable=1 also reads one pair from the read bank.
  - rd_cnt (9 bit) drives the read addresses A = {rd[8:2],0,rd[1:0]} and B = {rd[8:2],1,rd[1:0]}.
  - rd_cnt increments per read and wraps 511→0, in step with the write counter.
- Output mux: selected by the bank_sel value registered in the read cycle. The read strobe is delayed one cycle to form o_valid_out.
- Reads and writes always target opposite banks, so there is no read/write collision.
- Flush: a frame is emitted only while the next frame is being written. A final frame is flushed by feeding one dummy frame.

## Timing

- Pipeline for i_valid_in at cycle t:
  - Data is sampled and the butterfly computed at t+1 (registered).
  - RAM write at t+2.
  - Matching read (next frame) issued at t+2; o_valid_out and data at t+3.
- Continuous input from cycle 0: first o_valid_out at cycle 515 (frame 1, pair 0). Thereafter one output per input pair, each 3 cycles after its i_valid_in.
- Gaps in i_valid_in: counters and pipeline state hold; the output cadence mirrors the input gaps.
- Reset values:
  - o_valid_out = 0 and all o_data_* = 0.
  - in_cnt, rd_cnt, bank_sel, read_enable = 0; pipeline valid flags = 0.
  - RAM contents are not cleared.
- Reset mid-frame: the partial frame is discarded and no output appears until a full new frame plus one following pair.
- Bank swap at the 512th write and the wrap of both counters occur in the same cycle; the next write goes to the new bank.

## Test plan

- Reset: hold i_reset low with random inputs -> all outputs 0. After release with no valid input, o_valid_out stays 0.
- Even-pair twiddle: frame 0 pair 0 with A=0x00001000, B=0x00000800 (imag 0), then one flush frame -> output 0 A slot real = 0x00000C00; index-2 slot real = 0x00000400; imag = 0.
- Odd-pair twiddle: pair 1 with A=0x00001000+j0, B=0x00000800+j0 -> index 1 = (0x00000800, 0xFFFFFC00), index 3 = (0x00000800, 0x00000400).
- Reorder: frame 0 with A.real = 2j and B.real = 2j+1 for pair j, imag 0, plus a flush frame -> first output pair combines indices 0/4, second 1/5, fifth 8/12. o_valid_out rises at cycle 515.
- Extremes: A=B=0x7FFFFFFF on an even pair -> A'=0x7FFFFFFF, B'=0. A=B=0x80000000 on an odd pair (real only) -> A' = (0xC0000000, 0x40000000), B' = (0xC0000000, 0xC0000000).
- Gaps and reset: random idle cycles between pairs -> output values match the gap-free run. Asserting i_reset at pair 300 of frame 1 -> o_valid_out drops within 1 cycle, and the next outputs equal those of a fresh two-frame run.
